// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode constants, op-code enumeration and the field decoder used ahead of the
// decode-stage pipeline registers.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  localparam int unsigned CLS_BRANCH = 4;
  localparam int unsigned CLS_JUMP   = 3;
  localparam int unsigned CLS_LOAD   = 2;
  localparam int unsigned CLS_STORE  = 1;
  localparam int unsigned CLS_SYSTEM = 0;

  // OP_MUL..OP_REMU must stay contiguous and in funct3 order.
  typedef enum logic [5:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_FENCE, OP_ECALL, OP_EBREAK,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_ILLEGAL = 6'h3F
  } op_e;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} skid_state_e;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] cls;
    logic       illegal;
  } dec_t;

  function automatic dec_t decode_instr(input logic [31:0] instr, input logic en_m);
    dec_t       d;
    logic       ill;
    logic [2:0] f3;
    logic [6:0] f7;
    f3     = instr[14:12];
    f7     = instr[31:25];
    d      = '0;
    d.op   = OP_ILLEGAL;
    ill    = 1'b0;
    case (instr[6:0])
      OPC_LUI: begin
        d.op = OP_LUI;
        d.rd = instr[11:7];
      end
      OPC_AUIPC: begin
        d.op = OP_AUIPC;
        d.rd = instr[11:7];
      end
      OPC_JAL: begin
        d.op           = OP_JAL;
        d.rd           = instr[11:7];
        d.cls[CLS_JUMP] = 1'b1;
      end
      OPC_JALR: begin
        d.op            = OP_JALR;
        d.rd            = instr[11:7];
        d.rs1           = instr[19:15];
        d.cls[CLS_JUMP] = 1'b1;
        ill             = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        d.rs1             = instr[19:15];
        d.rs2             = instr[24:20];
        d.cls[CLS_BRANCH] = 1'b1;
        case (f3)
          F3_BEQ:  d.op = OP_BEQ;
          F3_BNE:  d.op = OP_BNE;
          F3_BLT:  d.op = OP_BLT;
          F3_BGE:  d.op = OP_BGE;
          F3_BLTU: d.op = OP_BLTU;
          F3_BGEU: d.op = OP_BGEU;
          default: ill  = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d.rd            = instr[11:7];
        d.rs1           = instr[19:15];
        d.cls[CLS_LOAD] = 1'b1;
        case (f3)
          F3_LB:   d.op = OP_LB;
          F3_LH:   d.op = OP_LH;
          F3_LW:   d.op = OP_LW;
          F3_LBU:  d.op = OP_LBU;
          F3_LHU:  d.op = OP_LHU;
          default: ill  = 1'b1;
        endcase
      end
      OPC_STORE: begin
        d.rs1            = instr[19:15];
        d.rs2            = instr[24:20];
        d.cls[CLS_STORE] = 1'b1;
        case (f3)
          F3_SB:   d.op = OP_SB;
          F3_SH:   d.op = OP_SH;
          F3_SW:   d.op = OP_SW;
          default: ill  = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        d.rd  = instr[11:7];
        d.rs1 = instr[19:15];
        case (f3)
          F3_ADD:  d.op = OP_ADDI;
          F3_SLT:  d.op = OP_SLTI;
          F3_SLTU: d.op = OP_SLTIU;
          F3_XOR:  d.op = OP_XORI;
          F3_OR:   d.op = OP_ORI;
          F3_AND:  d.op = OP_ANDI;
          F3_SLL: begin
            d.op = OP_SLLI;
            ill  = (f7 != F7_BASE);
          end
          default: begin
            d.op = (f7 == F7_ALT) ? OP_SRAI : OP_SRLI;
            ill  = (f7 != F7_BASE) && (f7 != F7_ALT);
          end
        endcase
      end
      OPC_OP: begin
        d.rd  = instr[11:7];
        d.rs1 = instr[19:15];
        d.rs2 = instr[24:20];
        if (f7 == F7_BASE) begin
          case (f3)
            F3_ADD:  d.op = OP_ADD;
            F3_SLL:  d.op = OP_SLL;
            F3_SLT:  d.op = OP_SLT;
            F3_SLTU: d.op = OP_SLTU;
            F3_XOR:  d.op = OP_XOR;
            F3_SRL:  d.op = OP_SRL;
            F3_OR:   d.op = OP_OR;
            default: d.op = OP_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == F3_ADD) begin
          d.op = OP_SUB;
        end else if (f7 == F7_ALT && f3 == F3_SRL) begin
          d.op = OP_SRA;
        end else if (f7 == F7_MULDIV && en_m) begin
          d.op = 6'(OP_MUL) + {3'b000, f3};
        end else begin
          ill = 1'b1;
        end
      end
      OPC_MISC_MEM: begin
        d.op = OP_FENCE;
        ill  = (f3 != 3'b000);
      end
      OPC_SYSTEM: begin
        d.cls[CLS_SYSTEM] = 1'b1;
        if (instr == 32'h0000_0073) begin
          d.op = OP_ECALL;
        end else if (instr == 32'h0010_0073) begin
          d.op = OP_EBREAK;
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      d         = '0;
      d.op      = OP_ILLEGAL;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J (or shift-amount) immediate from the opcode and
// sign-extends it to XLEN. Pure combinational so other units can share it.
module decode_stage_imm_gen
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm
);

  logic signed [31:0] w_imm32;

  always_comb begin
    w_imm32 = '0;
    case (i_instr[6:0])
      OPC_LOAD, OPC_JALR: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      OPC_OP_IMM: begin
        // funct3 001/101 are the shifts: immediate is the raw shift amount.
        if (i_instr[13:12] == 2'b01) begin
          w_imm32 = {27'b0, i_instr[24:20]};
        end else begin
          w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
        end
      end
      OPC_STORE:  w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OPC_BRANCH: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                             i_instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: w_imm32 = {i_instr[31:12], 12'b0};
      OPC_JAL:    w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                             i_instr[30:21], 1'b0};
      default:    w_imm32 = '0;
    endcase
  end

  assign o_imm = XLEN'(w_imm32);

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes in_instr combinationally, then holds the bundle in a
// main register backed by an optional skid register so in_ready never depends on out_ready.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned EN_M = 0,
  parameter int unsigned SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [5:0]      out_op,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_cls,
  output logic            out_illegal
);

  dec_t            w_dec;
  logic [XLEN-1:0] w_imm_raw;
  logic [XLEN-1:0] w_imm;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_load_main_in;
  logic            w_load_main_skid;
  logic            w_load_skid;
  logic            w_in_ready_d;
  skid_state_e     w_state_d;

  skid_state_e     r_state;
  logic            r_in_ready;
  dec_t            r_main_dec;
  logic [XLEN-1:0] r_main_pc;
  logic [XLEN-1:0] r_main_imm;
  dec_t            r_skid_dec;
  logic [XLEN-1:0] r_skid_pc;
  logic [XLEN-1:0] r_skid_imm;

  assign w_dec = decode_instr(in_instr, EN_M != 0);

  decode_stage_imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .i_instr(in_instr),
    .o_imm  (w_imm_raw)
  );

  assign w_imm = w_dec.illegal ? '0 : w_imm_raw;

  assign out_valid  = (r_state != StEmpty);
  assign in_ready   = (SKID != 0) ? r_in_ready : ((r_state == StEmpty) | out_ready);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_state_d        = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_d = StEmpty;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_in_fire) begin
            w_load_main_in = 1'b1;
            w_state_d      = StOne;
          end
        end
        StOne: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main_in = 1'b1;
          end else if (w_in_fire) begin
            // Unreachable with SKID=0: in_ready there requires out_ready when full.
            w_load_skid = 1'b1;
            w_state_d   = StTwo;
          end else if (w_out_fire) begin
            w_state_d = StEmpty;
          end
        end
        StTwo: begin
          if (w_out_fire) begin
            w_load_main_skid = 1'b1;
            w_state_d        = StOne;
          end
        end
        default: w_state_d = StEmpty;
      endcase
    end
    w_in_ready_d = (w_state_d != StTwo);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StEmpty;
      r_in_ready <= 1'b1;
      r_main_dec <= '0;
      r_main_pc  <= '0;
      r_main_imm <= '0;
      r_skid_dec <= '0;
      r_skid_pc  <= '0;
      r_skid_imm <= '0;
    end else begin
      r_state    <= w_state_d;
      r_in_ready <= w_in_ready_d;
      if (w_load_main_in) begin
        r_main_dec <= w_dec;
        r_main_pc  <= in_pc;
        r_main_imm <= w_imm;
      end else if (w_load_main_skid) begin
        r_main_dec <= r_skid_dec;
        r_main_pc  <= r_skid_pc;
        r_main_imm <= r_skid_imm;
      end
      if (w_load_skid) begin
        r_skid_dec <= w_dec;
        r_skid_pc  <= in_pc;
        r_skid_imm <= w_imm;
      end
    end
  end

  assign out_pc      = r_main_pc;
  assign out_op      = r_main_dec.op;
  assign out_rd      = r_main_dec.rd;
  assign out_rs1     = r_main_dec.rs1;
  assign out_rs2     = r_main_dec.rs2;
  assign out_imm     = r_main_imm;
  assign out_cls     = r_main_dec.cls;
  assign out_illegal = r_main_dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (EN_M=0/1) checked every cycle against a mask/match
// instruction-table model and a transaction queue, plus directed literal expectations.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;

  logic [1:0]  in_ready;
  logic [1:0]  out_valid;
  logic [1:0]  out_illegal;
  logic [31:0] out_pc  [2];
  logic [31:0] out_imm [2];
  logic [5:0]  out_op  [2];
  logic [4:0]  out_rd  [2];
  logic [4:0]  out_rs1 [2];
  logic [4:0]  out_rs2 [2];
  logic [4:0]  out_cls [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    decode_stage #(
      .XLEN(32),
      .EN_M(g),
      .SKID(1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready[g]),
      .in_instr   (in_instr),
      .in_pc      (in_pc),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready),
      .out_pc     (out_pc[g]),
      .out_op     (out_op[g]),
      .out_rd     (out_rd[g]),
      .out_rs1    (out_rs1[g]),
      .out_rs2    (out_rs2[g]),
      .out_imm    (out_imm[g]),
      .out_cls    (out_cls[g]),
      .out_illegal(out_illegal[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- instruction-table model ----------------
  typedef enum int {FR, FI, FSH, FS, FB, FU, FJ, FN} fmt_e;
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [5:0]  op;
    fmt_e        fmt;
    bit          m_ext;
  } ent_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  cls;
    logic        ill;
  } exp_t;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } txn_t;

  ent_t tbl[$];
  txn_t q[$];

  task automatic add(input logic [31:0] mask, input logic [31:0] match, input logic [5:0] op,
                     input fmt_e fmt, input bit m);
    ent_t e;
    e.mask = mask; e.match = match; e.op = op; e.fmt = fmt; e.m_ext = m;
    tbl.push_back(e);
  endtask

  task automatic build_table();
    localparam logic [31:0] M7 = 32'h0000_007F;
    localparam logic [31:0] M3 = 32'h0000_707F;
    localparam logic [31:0] MR = 32'hFE00_707F;
    add(M7, 32'h37, OP_LUI, FU, 0);          add(M7, 32'h17, OP_AUIPC, FU, 0);
    add(M7, 32'h6F, OP_JAL, FJ, 0);          add(M3, 32'h67, OP_JALR, FI, 0);
    add(M3, 32'h0063, OP_BEQ, FB, 0);        add(M3, 32'h1063, OP_BNE, FB, 0);
    add(M3, 32'h4063, OP_BLT, FB, 0);        add(M3, 32'h5063, OP_BGE, FB, 0);
    add(M3, 32'h6063, OP_BLTU, FB, 0);       add(M3, 32'h7063, OP_BGEU, FB, 0);
    add(M3, 32'h0003, OP_LB, FI, 0);         add(M3, 32'h1003, OP_LH, FI, 0);
    add(M3, 32'h2003, OP_LW, FI, 0);         add(M3, 32'h4003, OP_LBU, FI, 0);
    add(M3, 32'h5003, OP_LHU, FI, 0);        add(M3, 32'h0023, OP_SB, FS, 0);
    add(M3, 32'h1023, OP_SH, FS, 0);         add(M3, 32'h2023, OP_SW, FS, 0);
    add(M3, 32'h0013, OP_ADDI, FI, 0);       add(M3, 32'h2013, OP_SLTI, FI, 0);
    add(M3, 32'h3013, OP_SLTIU, FI, 0);      add(M3, 32'h4013, OP_XORI, FI, 0);
    add(M3, 32'h6013, OP_ORI, FI, 0);        add(M3, 32'h7013, OP_ANDI, FI, 0);
    add(MR, 32'h1013, OP_SLLI, FSH, 0);      add(MR, 32'h5013, OP_SRLI, FSH, 0);
    add(MR, 32'h4000_5013, OP_SRAI, FSH, 0);
    add(MR, 32'h0033, OP_ADD, FR, 0);        add(MR, 32'h4000_0033, OP_SUB, FR, 0);
    add(MR, 32'h1033, OP_SLL, FR, 0);        add(MR, 32'h2033, OP_SLT, FR, 0);
    add(MR, 32'h3033, OP_SLTU, FR, 0);       add(MR, 32'h4033, OP_XOR, FR, 0);
    add(MR, 32'h5033, OP_SRL, FR, 0);        add(MR, 32'h4000_5033, OP_SRA, FR, 0);
    add(MR, 32'h6033, OP_OR, FR, 0);         add(MR, 32'h7033, OP_AND, FR, 0);
    add(M3, 32'h000F, OP_FENCE, FN, 0);
    add(32'hFFFF_FFFF, 32'h73, OP_ECALL, FN, 0);
    add(32'hFFFF_FFFF, 32'h0010_0073, OP_EBREAK, FN, 0);
    add(MR, 32'h0200_0033, OP_MUL, FR, 1);   add(MR, 32'h0200_1033, OP_MULH, FR, 1);
    add(MR, 32'h0200_2033, OP_MULHSU, FR, 1); add(MR, 32'h0200_3033, OP_MULHU, FR, 1);
    add(MR, 32'h0200_4033, OP_DIV, FR, 1);   add(MR, 32'h0200_5033, OP_DIVU, FR, 1);
    add(MR, 32'h0200_6033, OP_REM, FR, 1);   add(MR, 32'h0200_7033, OP_REMU, FR, 1);
  endtask

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc, input bit en_m);
    exp_t e;
    int   hit;
    int   si;
    fmt_e f;
    hit = -1;
    foreach (tbl[k]) begin
      if (hit < 0 && (i & tbl[k].mask) == tbl[k].match && (!tbl[k].m_ext || en_m)) hit = k;
    end
    e.pc = pc; e.imm = '0; e.rd = '0; e.rs1 = '0; e.rs2 = '0; e.cls = '0;
    if (hit < 0) begin
      e.op  = OP_ILLEGAL;
      e.ill = 1'b1;
      return e;
    end
    e.op  = tbl[hit].op;
    e.ill = 1'b0;
    f     = tbl[hit].fmt;
    si    = $signed(i);
    if (f inside {FR, FI, FSH, FU, FJ}) e.rd  = i[11:7];
    if (f inside {FR, FI, FSH, FS, FB}) e.rs1 = i[19:15];
    if (f inside {FR, FS, FB})          e.rs2 = i[24:20];
    case (f)
      FI:  e.imm = 32'(si >>> 20);
      FSH: e.imm = 32'(i[24:20]);
      FS:  e.imm = 32'((si >>> 25) * 32 + int'(i[11:7]));
      FB:  e.imm = 32'((si >>> 31) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32
                       + int'(i[11:8]) * 2);
      FU:  e.imm = i & 32'hFFFF_F000;
      FJ:  e.imm = 32'((si >>> 31) * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                       + int'(i[30:21]) * 2);
      default: e.imm = '0;
    endcase
    e.cls[4] = (f == FB);
    e.cls[3] = (e.op == OP_JAL) || (e.op == OP_JALR);
    e.cls[2] = e.op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    e.cls[1] = (f == FS);
    e.cls[0] = (e.op == OP_ECALL) || (e.op == OP_EBREAK);
    return e;
  endfunction

  // Transaction queue: capacity two, flush/reset empty it, latency one.
  always @(posedge clk or posedge rst) begin : mdl
    bit inf;
    bit outf;
    txn_t t;
    if (rst) begin
      q.delete();
    end else begin
      inf  = in_valid && (q.size() < 2);
      outf = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (outf) void'(q.pop_front());
        if (inf) begin
          t.instr = in_instr;
          t.pc    = in_pc;
          q.push_back(t);
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    exp_t e;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("cmp%0d_in_ready", d), in_ready[d], q.size() < 2);
        chk($sformatf("cmp%0d_out_valid", d), out_valid[d], q.size() > 0);
        if (q.size() > 0) begin
          e = model(q[0].instr, q[0].pc, d == 1);
          chk($sformatf("cmp%0d_pc", d), out_pc[d], e.pc);
          chk($sformatf("cmp%0d_op", d), out_op[d], e.op);
          chk($sformatf("cmp%0d_rd", d), out_rd[d], e.rd);
          chk($sformatf("cmp%0d_rs1", d), out_rs1[d], e.rs1);
          chk($sformatf("cmp%0d_rs2", d), out_rs2[d], e.rs2);
          chk($sformatf("cmp%0d_imm", d), out_imm[d], e.imm);
          chk($sformatf("cmp%0d_cls", d), out_cls[d], e.cls);
          chk($sformatf("cmp%0d_illegal", d), out_illegal[d], e.ill);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
  endtask

  logic [31:0] vec [12] = '{
    32'h1234_50B7, 32'h0080_00EF, 32'h0011_2223, 32'hFFC1_2183,
    32'h4030_D213, 32'h0200_D213, 32'h0000_80E7, 32'h0000_000F,
    32'h0010_0073, 32'h0220_C233, 32'h0020_8032, 32'h8000_0AB7
  };

  initial begin
    logic [31:0] got[$];
    bit          acc;
    int          idx;
    build_table();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_out_valid", out_valid[0], 1'b0);
    chk("rst_out_op", out_op[0], 6'd0);
    chk("rst_out_imm", out_imm[0], 32'd0);
    chk("rst_out_pc", out_pc[0], 32'd0);
    chk("rst_in_ready", in_ready[0], 1'b1);

    // addi x1,x0,5
    drive(32'h0050_0093, 32'h100);
    step();
    chk("t1_valid", out_valid[0], 1'b1);
    chk("t1_op", out_op[0], OP_ADDI);
    chk("t1_rd", out_rd[0], 5'd1);
    chk("t1_rs1", out_rs1[0], 5'd0);
    chk("t1_imm", out_imm[0], 32'd5);
    chk("t1_illegal", out_illegal[0], 1'b0);

    // beq x0,x0,-4
    drive(32'hFE00_0EE3, 32'h104);
    step();
    chk("t2_op", out_op[0], OP_BEQ);
    chk("t2_cls", out_cls[0], 5'b10000);
    chk("t2_rd", out_rd[0], 5'd0);
    chk("t2_imm", out_imm[0], 32'hFFFF_FFFC);

    // sub, then mul: illegal without M, OP_MUL with M
    drive(32'h4020_8033, 32'h108);
    step();
    chk("t3_sub_m0", out_op[0], OP_SUB);
    chk("t3_sub_m1", out_op[1], OP_SUB);
    drive(32'h0220_8033, 32'h10C);
    step();
    chk("t3_mul_m0_illegal", out_illegal[0], 1'b1);
    chk("t3_mul_m0_op", out_op[0], OP_ILLEGAL);
    chk("t3_mul_m1_op", out_op[1], OP_MUL);
    chk("t3_mul_m1_illegal", out_illegal[1], 1'b0);

    // ecall, all-ones
    drive(32'h0000_0073, 32'h110);
    step();
    chk("t6_ecall_op", out_op[0], OP_ECALL);
    chk("t6_ecall_cls", out_cls[0], 5'b00001);
    drive(32'hFFFF_FFFF, 32'h114);
    step();
    in_valid = 1'b0;
    chk("t6_ones_illegal", out_illegal[0], 1'b1);
    chk("t6_ones_op", out_op[0], OP_ILLEGAL);
    chk("t6_ones_imm", out_imm[0], 32'd0);
    step();

    // backpressure: three offered, two accepted, output held
    out_ready = 1'b0;
    drive(32'h0010_0293, 32'h200);
    step();
    chk("t4_hold0_pc", out_pc[0], 32'h200);
    drive(32'h0020_0313, 32'h204);
    step();
    chk("t4_hold1_pc", out_pc[0], 32'h200);
    chk("t4_full_in_ready", in_ready[0], 1'b0);
    drive(32'h0030_0393, 32'h208);
    step();
    chk("t4_hold2_pc", out_pc[0], 32'h200);
    chk("t4_hold2_op", out_op[0], OP_ADDI);
    chk("t4_stall_in_ready", in_ready[0], 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (out_valid[0] && out_ready) got.push_back(out_pc[0]);
      acc = in_valid && in_ready[0];
      step();
      if (acc) in_valid = 1'b0;
      if (got.size() == 3) break;
    end
    in_valid = 1'b0;
    chk("t4_drain_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("t4_order0", got[0], 32'h200);
      chk("t4_order1", got[1], 32'h204);
      chk("t4_order2", got[2], 32'h208);
    end

    // flush with two held plus an offered instr
    out_ready = 1'b0;
    drive(32'h0010_0293, 32'h300);
    step();
    drive(32'h0020_0313, 32'h304);
    step();
    drive(32'h0030_0393, 32'h308);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5a_valid", out_valid[0], 1'b0);
    chk("t5a_in_ready", in_ready[0], 1'b1);
    // flush with one held while in_ready is high: the offered instr must be dropped
    drive(32'h0010_0293, 32'h320);
    step();
    drive(32'h0020_0313, 32'h324);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5b_valid", out_valid[0], 1'b0);
    out_ready = 1'b1;
    drive(32'h0030_0393, 32'h328);
    step();
    in_valid = 1'b0;
    chk("t5b_first_pc", out_pc[0], 32'h328);
    step();

    // reset pulsed mid-stream
    out_ready = 1'b0;
    drive(32'h0050_0093, 32'h400);
    step();
    in_valid = 1'b0;
    chk("t6_pre_rst_valid", out_valid[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid0", out_valid[0], 1'b0);
    chk("t6_rst_valid1", out_valid[1], 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("t6_post_rst_valid", out_valid[0], 1'b0);
    chk("t6_post_rst_op", out_op[0], 6'd0);
    chk("t6_post_rst_in_ready", in_ready[0], 1'b1);

    // mixed vectors with intermittent backpressure; the per-cycle model does the checking
    idx = 0;
    for (int c = 0; c < 80 && idx < 12; c++) begin
      out_ready = (c % 4) != 3;
      drive(vec[idx], 32'h1000 + 32'(idx) * 4);
      acc = in_ready[0];
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("vec_all_sent", idx, 12);
    out_ready = 1'b1;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
